// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for an RV32I core: sequences fetch, decode, data access and
// pc update, with a bus-timeout watchdog on both request/ack handshakes.
module pc_sequencer #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        run,
  input  logic        instr_ack,
  input  logic        mem_ack,
  input  logic        dec_halt,
  input  logic        dec_jump,
  input  logic        dec_branch,
  input  logic        dec_load,
  input  logic        dec_store,
  input  logic        branch_taken,
  output logic        instr_req,
  output logic        ir_we,
  output logic        mem_req,
  output logic        mem_we,
  output logic        reg_we,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        pc_branch,
  output logic        pc_disable,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired_cnt,
  output logic [2:0]  state
);

  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    C_ALU    = 3'd0,
    C_JUMP   = 3'd1,
    C_BRANCH = 3'd2,
    C_LOAD   = 3'd3,
    C_STORE  = 3'd4
  } cls_t;

  state_t            cur;
  cls_t              cls;
  cls_t              dec_cls;
  logic [WAIT_W-1:0] wait_cnt;
  logic [31:0]       retired;
  logic              upd;

  // Class priority among non-halt instructions: jump > branch > load > store > ALU.
  function automatic cls_t classify(input logic j, input logic b, input logic l, input logic s);
    if (j)      return C_JUMP;
    else if (b) return C_BRANCH;
    else if (l) return C_LOAD;
    else if (s) return C_STORE;
    else        return C_ALU;
  endfunction

  assign dec_cls = classify(dec_jump, dec_branch, dec_load, dec_store);

  always_ff @(posedge clk) begin
    if (!clr) begin
      cur      <= S_IDLE;
      cls      <= C_ALU;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (run) begin
            cur      <= S_FETCH;
            wait_cnt <= '0;
          end
        end
        S_FETCH: begin
          // An ack in the final allowed cycle takes precedence over the timeout.
          if (instr_ack)                  cur <= S_DECODE;
          else if (wait_cnt == WAIT_LAST) cur <= S_FAULT;
          else                            wait_cnt <= wait_cnt + 1'b1;
        end
        S_DECODE: begin
          cls <= dec_cls;
          if (dec_halt) begin
            cur <= S_HALT;
          end else if (dec_cls == C_LOAD || dec_cls == C_STORE) begin
            cur      <= S_MEM;
            wait_cnt <= '0;
          end else begin
            cur <= S_UPDATE;
          end
        end
        S_MEM: begin
          if (mem_ack)                    cur <= S_UPDATE;
          else if (wait_cnt == WAIT_LAST) cur <= S_FAULT;
          else                            wait_cnt <= wait_cnt + 1'b1;
        end
        S_UPDATE: begin
          retired  <= retired + 32'd1;
          wait_cnt <= '0;
          cur      <= run ? S_FETCH : S_IDLE;
        end
        S_HALT:  cur <= S_HALT;
        S_FAULT: cur <= S_FAULT;
        default: cur <= S_IDLE;
      endcase
    end
  end

  assign upd         = (cur == S_UPDATE);
  assign state       = cur;
  assign instr_req   = (cur == S_FETCH);
  assign ir_we       = instr_req & instr_ack;
  assign mem_req     = (cur == S_MEM);
  assign mem_we      = mem_req && (cls == C_STORE);
  assign pc_load     = upd && (cls == C_JUMP);
  assign pc_branch   = upd && (cls == C_BRANCH) && branch_taken;
  assign pc_inc      = upd && !pc_load && !pc_branch;
  assign reg_we      = upd && (cls == C_ALU || cls == C_LOAD || cls == C_JUMP);
  assign pc_disable  = !upd;
  assign halted      = (cur == S_HALT);
  assign fault       = (cur == S_FAULT);
  assign retired_cnt = retired;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a 4-cycle bus timeout; expected values are hand-computed.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clr, run, instr_ack, mem_ack;
  logic        dec_halt, dec_jump, dec_branch, dec_load, dec_store, branch_taken;
  logic        instr_req, ir_we, mem_req, mem_we, reg_we;
  logic        pc_inc, pc_load, pc_branch, pc_disable, halted, fault;
  logic [31:0] retired_cnt;
  logic [2:0]  state;

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .clr(clr), .run(run), .instr_ack(instr_ack), .mem_ack(mem_ack),
    .dec_halt(dec_halt), .dec_jump(dec_jump), .dec_branch(dec_branch),
    .dec_load(dec_load), .dec_store(dec_store), .branch_taken(branch_taken),
    .instr_req(instr_req), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
    .reg_we(reg_we), .pc_inc(pc_inc), .pc_load(pc_load), .pc_branch(pc_branch),
    .pc_disable(pc_disable), .halted(halted), .fault(fault),
    .retired_cnt(retired_cnt), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_dec();
    dec_halt = 0; dec_jump = 0; dec_branch = 0; dec_load = 0; dec_store = 0;
  endtask

  // Runs one instruction starting in FETCH cycle 1 and checks the UPDATE strobes.
  task automatic exec(input string name, input int fw, input logic j, input logic b,
                      input logic l, input logic s, input logic tk, input int e_mc,
                      input logic e_inc, input logic e_ld, input logic e_br,
                      input logic e_rwe, input logic e_mwe, input int e_ret);
    int mc;
    for (int i = 0; i < fw; i++) tick();
    chk({name, "_fetch_state"}, 32'(state), 32'd1);
    instr_ack = 1;
    #1;
    chk({name, "_ir_we"}, 32'(ir_we), 32'd1);
    tick();
    instr_ack = 0;
    dec_jump = j; dec_branch = b; dec_load = l; dec_store = s;
    branch_taken = tk;
    chk({name, "_decode_state"}, 32'(state), 32'd2);
    tick();
    clear_dec();
    mc = 0;
    for (int g = 0; g < 20 && state == 3'd3; g++) begin
      mc++;
      if (mc == 1) begin
        chk({name, "_mem_req"}, 32'(mem_req), 32'd1);
        chk({name, "_mem_we"}, 32'(mem_we), 32'(e_mwe));
      end
      if (mc == e_mc) mem_ack = 1;
      tick();
      mem_ack = 0;
    end
    chk({name, "_mem_cycles"}, 32'(mc), 32'(e_mc));
    chk({name, "_upd_state"}, 32'(state), 32'd4);
    chk({name, "_pc_inc"}, 32'(pc_inc), 32'(e_inc));
    chk({name, "_pc_load"}, 32'(pc_load), 32'(e_ld));
    chk({name, "_pc_branch"}, 32'(pc_branch), 32'(e_br));
    chk({name, "_reg_we"}, 32'(reg_we), 32'(e_rwe));
    chk({name, "_pc_disable"}, 32'(pc_disable), 32'd0);
    tick();
    branch_taken = 0;
    chk({name, "_retired"}, retired_cnt, 32'(e_ret));
    chk({name, "_next_fetch"}, 32'(state), 32'd1);
    chk({name, "_pulse_gone"}, 32'({pc_inc, pc_load, pc_branch, reg_we}), 32'd0);
  endtask

  initial begin
    clr = 0; run = 0; instr_ack = 0; mem_ack = 0; branch_taken = 0;
    clear_dec();

    // Reset state
    tick(); tick();
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc_disable", 32'(pc_disable), 32'd1);
    chk("rst_outs", 32'({instr_req, ir_we, mem_req, mem_we, reg_we, pc_inc,
                         pc_load, pc_branch, halted, fault}), 32'd0);
    chk("rst_retired", retired_cnt, 32'd0);
    clr = 1;
    tick();
    chk("idle_hold", 32'(state), 32'd0);

    run = 1;
    tick();
    chk("fetch_req", 32'(instr_req), 32'd1);
    chk("fetch_ir_we_noack", 32'(ir_we), 32'd0);

    //   name      fw j b l s tk mc inc ld br rwe mwe ret
    exec("alu",    1, 0,0,0,0, 0, 0, 1, 0, 0, 1,  0,  1);
    exec("store",  0, 0,0,0,1, 0, 3, 1, 0, 0, 0,  1,  2);
    exec("load",   0, 0,0,1,0, 0, 3, 1, 0, 0, 1,  0,  3);
    exec("br_tk",  0, 0,1,0,0, 1, 0, 0, 0, 1, 0,  0,  4);
    exec("br_nt",  0, 0,1,0,0, 0, 0, 1, 0, 0, 0,  0,  5);
    exec("jmp_br", 0, 1,1,0,0, 1, 0, 0, 1, 0, 1,  0,  6);
    exec("jmp_ld", 2, 1,0,1,0, 0, 0, 0, 1, 0, 1,  0,  7);

    // Fetch timeout: 4 ack-less cycles then FAULT
    tick(); tick(); tick();
    chk("to_cycle4_state", 32'(state), 32'd1);
    tick();
    chk("to_fault_state", 32'(state), 32'd6);
    chk("to_fault_flag", 32'(fault), 32'd1);
    chk("to_instr_req", 32'(instr_req), 32'd0);
    instr_ack = 1;
    tick();
    instr_ack = 0;
    chk("to_late_ack_state", 32'(state), 32'd6);
    chk("to_late_ack_ir_we", 32'(ir_we), 32'd0);

    clr = 0;
    tick();
    clr = 1;
    chk("to_rst_state", 32'(state), 32'd0);
    chk("to_rst_fault", 32'(fault), 32'd0);
    chk("to_rst_retired", retired_cnt, 32'd0);

    // Ack on the last allowed cycle wins
    tick();
    tick(); tick(); tick();
    chk("last_ack_fetch", 32'(state), 32'd1);
    instr_ack = 1;
    tick();
    instr_ack = 0;
    chk("last_ack_decode", 32'(state), 32'd2);
    chk("last_ack_nofault", 32'(fault), 32'd0);
    tick();
    chk("last_ack_update", 32'(state), 32'd4);
    tick();
    chk("last_ack_retired", retired_cnt, 32'd1);

    // Reset in the middle of a data access
    instr_ack = 1;
    tick();
    instr_ack = 0;
    dec_load = 1;
    tick();
    clear_dec();
    chk("mid_mem_state", 32'(state), 32'd3);
    clr = 0;
    tick();
    clr = 1;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_mem_req", 32'(mem_req), 32'd0);
    chk("mid_rst_retired", retired_cnt, 32'd0);
    run = 0; mem_ack = 1; instr_ack = 1;
    tick();
    mem_ack = 0; instr_ack = 0;
    chk("post_rst_ack_ignored", 32'(state), 32'd0);

    // ALU then halt
    run = 1;
    tick();
    exec("alu2", 0, 0,0,0,0, 0, 0, 1, 0, 0, 1, 0, 1);
    instr_ack = 1;
    tick();
    instr_ack = 0;
    dec_halt = 1; dec_jump = 1;
    tick();
    clear_dec();
    chk("halt_state", 32'(state), 32'd5);
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_pc_disable", 32'(pc_disable), 32'd1);
    chk("halt_retired", retired_cnt, 32'd1);
    tick(); tick();
    chk("halt_sticky", 32'(halted), 32'd1);
    chk("halt_no_strobe", 32'({pc_inc, pc_load, pc_branch, reg_we, instr_req}), 32'd0);

    // run dropped mid-instruction: instruction completes, then IDLE
    clr = 0;
    tick();
    clr = 1;
    tick();
    instr_ack = 1;
    tick();
    instr_ack = 0;
    run = 0;
    tick();
    chk("run_drop_update", 32'(state), 32'd4);
    tick();
    chk("run_drop_idle", 32'(state), 32'd0);
    chk("run_drop_retired", retired_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

endmodule
